rgb_fade_ctrl: RTL
==================

# rgb_fade_ctrl

Parametrised N-channel LED fade/PWM controller: the next generation of the fixed three-channel fade-plus-PWM pair. A single free-running PWM counter drives `NUM_CH` glitch-free PWM outputs, and a mode-selectable fade engine supplies the duties: off, static, breathe (triangle) or rotate (channel-to-channel crossfade). It sits directly between top-level mode/duty controls and the LED pins.

## Interface
- `PWM_INTERVAL`, 1200: PWM period in clk cycles (100 µs at 12 MHz); `MAX` = `PWM_INTERVAL`; `DW` = $clog2(`PWM_INTERVAL`+1).
- `NUM_CH`, 3: number of PWM channels, ≥2.
- `STEP_PERIODS`, 100: PWM periods between fade-level updates, ≥1.
- `DUTY_STEP`, 12: fade-level increment per update, 1..`MAX`.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  2  00 off, 01 static, 10 breathe, 11 rotate.
- `static_duty`  in  `NUM_CH`*`DW`  static duties; channel k at [k*`DW` +: `DW`].
- `ch_mask`  in  `NUM_CH`  channel enables for breathe mode.
- `pwm_out`  out  `NUM_CH`  PWM outputs, bit k = channel k.
- `period_start`  out  1  one-cycle pulse coinciding with the first output cycle of each period.

## Operation
- PWM counter `cnt` runs 0..`PWM_INTERVAL`-1 and wraps to 0. The boundary is `cnt`==`PWM_INTERVAL`-1.
- Each channel has an active duty register `duty[k]`, loaded only at the boundary. Next-period `pwm_out[k]` = (`cnt` < `duty[k]`).
  - Duty 0: never high.
  - Duty `MAX`: always high.
- `mode` is sampled only at the boundary into `mode_q`.
  - If the sampled mode differs from `mode_q`: level `L`=0, direction=up, rotate phase `p`=0, step prescaler=0.
- The step prescaler counts boundaries. At every `STEP_PERIODS`-th boundary, with no mode change, `L`/`p` update as follows:
  - Breathe, up: `L` = min(`L`+`DUTY_STEP`, `MAX`). On reaching `MAX`, direction becomes down.
  - Breathe, down: `L` = max(`L`-`DUTY_STEP`, 0). On reaching 0, direction becomes up.
  - Rotate: if `L`+`DUTY_STEP` ≥ `MAX`, then `p` = (`p`+1) mod `NUM_CH` and `L`=0. Otherwise `L` += `DUTY_STEP`.
  - Off/static: `L`, `p` held.
- Arithmetic uses `DW`+1 bits; no wrap-around of `L` is permitted.
- Duty loaded at the boundary uses the post-update `mode_q`/`L`/`p`:
  - Off: all 0.
  - Static: min(`static_duty[k]`, `MAX`), sampled at the boundary.
  - Breathe: `ch_mask[k]` ? `L` : 0.
  - Rotate: channel `p` gets `MAX`-`L`; channel (`p`+1) mod `NUM_CH` gets `L`; all other channels get 0.
- Rotate phase FSM has states `p` = 0..`NUM_CH`-1, linear wrap, and advances only as described above.
- Reset state:
  - `cnt`, `duty`, `L`, `p`, prescaler, `period_start` = 0.
  - `mode_q` = off, direction = up.
  - `pwm_out` = 0.

## Timing
- `pwm_out` and `period_start` are registered.
- On the cycle after the boundary cycle: `cnt`=0, the new duties are active, and `period_start`=1.
- Input changes to `mode`, `static_duty` and `ch_mask` never alter the period in progress. Latency to the outputs is up to `PWM_INTERVAL` cycles.
- Fade level changes every `STEP_PERIODS`*`PWM_INTERVAL` cycles.
  - Full breathe cycle = 2*ceil(`MAX`/`DUTY_STEP`) updates.
  - Full rotate cycle = `NUM_CH`*ceil(`MAX`/`DUTY_STEP`) updates.
- `rst` asserted in any cycle: on the next edge all state takes its reset values, and `pwm_out`=0 while `rst` is high. The first cycle after release has `cnt`=0 with duties 0. The first period after release is all-low; the first sampled mode takes effect at the end of that period.
- A mode change and a prescaler expiry at the same boundary: the mode change wins. Reset values are used and no step is applied.

## Test plan
Use `PWM_INTERVAL`=10, `NUM_CH`=3, `STEP_PERIODS`=2, `DUTY_STEP`=5.
- Reset: hold `rst` 3 cycles mid-period while in static with duty 7, then release.
  - `pwm_out`=000 during reset and for the first 10 cycles after release.
  - `period_start` pulses 10 cycles after release.
- Static: duties ch0=3, ch1=0, ch2=15.
  - Per period, ch0 is high for exactly the first 3 cycles.
  - ch1 is never high.
  - ch2 is high for all 10 cycles (15 clamped to 10).
- Breathe: `ch_mask`=101.
  - ch0/ch2 high counts per period follow 0,0,5,5,10,10,5,5,0,0,5,5, starting from the first mode-change period.
  - ch1 stays 0 throughout.
- Rotate: high counts (ch0,ch1,ch2) per period follow:
  - (10,0,0)×2, (5,5,0)×2, (0,10,0)×2, (0,5,5)×2, (0,0,10)×2, (5,0,5)×2, then (10,0,0).
- Mode change mid-period: switch static(3,3,3) to off at `cnt`=4.
  - The current period still has 3 high cycles per channel.
  - All channels are 0 from the next `period_start`.
- Reset mid-rotate at phase 2: after release, the rotate sequence restarts at (10,0,0) after the all-low first period.

Source files
------------

// File: rtl/rgb_fade_ctrl.sv
// N-channel LED fade/PWM controller: one free-running PWM counter, per-channel
// duty registers reloaded at each period boundary, and an off/static/breathe/rotate fade engine.
module rgb_fade_ctrl #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned STEP_PERIODS = 100,
    parameter int unsigned DUTY_STEP    = 12,
    localparam int unsigned DW          = $clog2(PWM_INTERVAL + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [NUM_CH*DW-1:0]   static_duty,
    input  logic [NUM_CH-1:0]      ch_mask,
    output logic [NUM_CH-1:0]      pwm_out,
    output logic                   period_start
);

    localparam int unsigned CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned AW = DW + 1;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_STATIC  = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_ROTATE  = 2'b11;

    localparam logic [DW-1:0] MAX_D      = DW'(PWM_INTERVAL);
    localparam logic [AW-1:0] MAX_A      = AW'(PWM_INTERVAL);
    localparam logic [AW-1:0] STEP_A     = AW'(DUTY_STEP);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PWM_INTERVAL - 1);
    localparam logic [SW-1:0] PRESC_LAST = SW'(STEP_PERIODS - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(NUM_CH - 1);

    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [1:0]    mode_q, mode_nxt;
    logic [DW-1:0] lvl_q, lvl_nxt;
    logic          dir_q, dir_nxt;
    logic [PW-1:0] ph_q, ph_nxt, ph_adj;
    logic [SW-1:0] presc_q, presc_nxt;
    logic [DW-1:0] duty_q   [NUM_CH];
    logic [DW-1:0] duty_nxt [NUM_CH];
    logic [NUM_CH-1:0] pwm_nxt;
    logic          bnd;
    logic [AW-1:0] lvl_ext, lvl_up;

    assign bnd     = (cnt_q == CNT_LAST);
    assign lvl_ext = {1'b0, lvl_q};
    assign lvl_up  = lvl_ext + STEP_A;
    assign ph_adj  = (ph_nxt == PH_LAST) ? '0 : ph_nxt + PW'(1);

    function automatic logic [DW-1:0] clamp_max(input logic [DW-1:0] d);
        return (d > MAX_D) ? MAX_D : d;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            mode_q       <= MODE_OFF;
            lvl_q        <= '0;
            dir_q        <= 1'b0;
            ph_q         <= '0;
            presc_q      <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) duty_q[k] <= '0;
        end else begin
            cnt_q        <= cnt_nxt;
            mode_q       <= mode_nxt;
            lvl_q        <= lvl_nxt;
            dir_q        <= dir_nxt;
            ph_q         <= ph_nxt;
            presc_q      <= presc_nxt;
            pwm_out      <= pwm_nxt;
            period_start <= bnd;
            for (int unsigned k = 0; k < NUM_CH; k++) duty_q[k] <= duty_nxt[k];
        end
    end

    // Next state: counter, mode sampling, prescaler, fade level and rotate phase
    always_comb begin
        cnt_nxt   = cnt_q + CW'(1);
        mode_nxt  = mode_q;
        lvl_nxt   = lvl_q;
        dir_nxt   = dir_q;
        ph_nxt    = ph_q;
        presc_nxt = presc_q;
        if (bnd) begin
            cnt_nxt  = '0;
            mode_nxt = mode;
            if (mode != mode_q) begin
                // A mode change restarts the fade and overrides any pending step
                lvl_nxt   = '0;
                dir_nxt   = 1'b0;
                ph_nxt    = '0;
                presc_nxt = '0;
            end else if (presc_q == PRESC_LAST) begin
                presc_nxt = '0;
                case (mode_q)
                    MODE_BREATHE: begin
                        if (!dir_q) begin
                            if (lvl_up >= MAX_A) begin
                                lvl_nxt = MAX_D;
                                dir_nxt = 1'b1;
                            end else begin
                                lvl_nxt = lvl_up[DW-1:0];
                            end
                        end else begin
                            if (lvl_ext <= STEP_A) begin
                                lvl_nxt = '0;
                                dir_nxt = 1'b0;
                            end else begin
                                lvl_nxt = DW'(lvl_ext - STEP_A);
                            end
                        end
                    end
                    MODE_ROTATE: begin
                        if (lvl_up >= MAX_A) begin
                            lvl_nxt = '0;
                            ph_nxt  = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
                        end else begin
                            lvl_nxt = lvl_up[DW-1:0];
                        end
                    end
                    default: ;
                endcase
            end else begin
                presc_nxt = presc_q + SW'(1);
            end
        end
    end

    // Outputs: duty reload at the boundary and next-cycle PWM compare
    always_comb begin
        pwm_nxt = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            duty_nxt[k] = duty_q[k];
            if (bnd) begin
                case (mode_nxt)
                    MODE_STATIC:  duty_nxt[k] = clamp_max(static_duty[k*DW +: DW]);
                    MODE_BREATHE: duty_nxt[k] = ch_mask[k] ? lvl_nxt : '0;
                    MODE_ROTATE: begin
                        if (PW'(k) == ph_nxt)      duty_nxt[k] = MAX_D - lvl_nxt;
                        else if (PW'(k) == ph_adj) duty_nxt[k] = lvl_nxt;
                        else                       duty_nxt[k] = '0;
                    end
                    default:      duty_nxt[k] = '0;
                endcase
            end
            pwm_nxt[k] = (DW'(cnt_nxt) < duty_nxt[k]);
        end
    end

endmodule
